// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M/RV64M multiply/divide unit for the execute stage.
//
// Handshake: a request is accepted when start=1, flush=0 and the unit is in
// IDLE or DONE. Operands, funct3 and rd_in are sampled on that rising edge.
// busy is high while the operation iterates (CALC and FIX), and start is
// ignored while busy is high. done is a one-cycle pulse; result and rd_out are
// valid with it and hold until the next completed operation. A flush while
// busy abandons the operation without a done pulse.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous, active-low reset
//   start        request pulse
//   funct3       000 MUL 001 MULH 010 MULHSU 011 MULHU
//                100 DIV 101 DIVU 110 REM 111 REMU
//   operand1     rs1 (multiplicand / dividend)
//   operand2     rs2 (multiplier / divisor)
//   rd_in        destination register of the request
//   flush        abort the in-flight operation
//   busy         operation in progress
//   done         one-cycle completion pulse
//   result       operation result
//   rd_out       destination register of the result
//   o_dbg_state  current FSM state (0 IDLE, 1 CALC, 2 FIX, 3 DONE)
// -----------------------------------------------------------------------------
module muldiv_unit #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] operand1,
   input  logic [XLEN-1:0] operand2,
   input  logic [4:0]      rd_in,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out,
   output logic [1:0]      o_dbg_state
);

   localparam int N  = XLEN / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [XLEN:0]   r_hi;      // mul: product high half, div: partial remainder
   logic [XLEN-1:0] r_lo;      // mul: multiplier / product low half, div: dividend / quotient
   logic [XLEN-1:0] r_b;       // mul: multiplicand magnitude, div: divisor magnitude
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_op;
   logic            r_neg_q;   // product / quotient must be negated
   logic            r_neg_r;   // remainder must be negated (dividend sign)
   logic [4:0]      r_rd;
   logic [XLEN-1:0] r_result;
   logic [4:0]      r_rd_out;

   // ---------------- request decode ----------------
   logic            w_accept;
   logic            w_is_div;
   logic            w_sgn1, w_sgn2, w_neg1, w_neg2;
   logic [XLEN-1:0] w_mag1, w_mag2;
   logic            w_div0, w_ovf, w_fast;
   logic [XLEN-1:0] w_fast_res;

   assign w_accept = start & ~flush & ((r_state == S_IDLE) | (r_state == S_DONE));
   assign w_is_div = funct3[2];
   assign w_sgn1   = (funct3 == 3'b001) | (funct3 == 3'b010) |
                     (funct3 == 3'b100) | (funct3 == 3'b110);
   assign w_sgn2   = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
   assign w_neg1   = w_sgn1 & operand1[XLEN-1];
   assign w_neg2   = w_sgn2 & operand2[XLEN-1];
   assign w_mag1   = w_neg1 ? (~operand1 + 1'b1) : operand1;
   assign w_mag2   = w_neg2 ? (~operand2 + 1'b1) : operand2;

   // Cases whose answer is fixed by the ISA and need no iteration.
   assign w_div0   = w_is_div & (operand2 == '0);
   assign w_ovf    = w_is_div & ~funct3[0] & (operand1 == MOST_NEG) & (operand2 == '1);
   assign w_fast   = w_div0 | w_ovf;

   always_comb begin
      w_fast_res = '0;
      if (w_div0)
         w_fast_res = funct3[1] ? operand1 : '1;
      else if (w_ovf)
         w_fast_res = funct3[1] ? '0 : MOST_NEG;
   end

   // ---------------- one CALC edge worth of iteration ----------------
   logic [XLEN:0]   w_hi_step, w_rem, w_sum;
   logic [XLEN-1:0] w_lo_step;

   always_comb begin
      w_hi_step = r_hi;
      w_lo_step = r_lo;
      w_rem     = '0;
      w_sum     = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (r_op[2]) begin
            // restoring division: shift in next dividend bit, subtract if it fits
            w_rem     = {w_hi_step[XLEN-1:0], w_lo_step[XLEN-1]};
            w_lo_step = {w_lo_step[XLEN-2:0], 1'b0};
            if (w_rem >= {1'b0, r_b}) begin
               w_rem        = w_rem - {1'b0, r_b};
               w_lo_step[0] = 1'b1;
            end
            w_hi_step = w_rem;
         end else begin
            // shift-add: add multiplicand when the retiring multiplier bit is set
            w_sum     = w_lo_step[0] ? (w_hi_step + {1'b0, r_b}) : w_hi_step;
            w_lo_step = {w_sum[0], w_lo_step[XLEN-1:1]};
            w_hi_step = {1'b0, w_sum[XLEN:1]};
         end
      end
   end

   // ---------------- sign fix and output select ----------------
   logic [2*XLEN-1:0] w_prod, w_prod_s;
   logic [XLEN-1:0]   w_quo_s, w_rem_s, w_fix_res;

   assign w_prod   = {r_hi[XLEN-1:0], r_lo};
   assign w_prod_s = r_neg_q ? (~w_prod + 1'b1) : w_prod;
   assign w_quo_s  = r_neg_q ? (~r_lo + 1'b1) : r_lo;
   assign w_rem_s  = r_neg_r ? (~r_hi[XLEN-1:0] + 1'b1) : r_hi[XLEN-1:0];

   always_comb begin
      w_fix_res = '0;
      case (r_op)
         3'b000:                 w_fix_res = w_prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: w_fix_res = w_prod_s[2*XLEN-1:XLEN];
         3'b100, 3'b101:         w_fix_res = w_quo_s;
         default:                w_fix_res = w_rem_s;
      endcase
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept) w_state_nxt = w_fast ? S_DONE : S_CALC;
            else          w_state_nxt = S_IDLE;
         end
         S_CALC: begin
            if (flush)                 w_state_nxt = S_IDLE;
            else if (r_cnt == CW'(1))  w_state_nxt = S_FIX;
            else                       w_state_nxt = S_CALC;
         end
         S_FIX: w_state_nxt = flush ? S_IDLE : S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy        = (r_state == S_CALC) | (r_state == S_FIX);
      done        = (r_state == S_DONE);
      o_dbg_state = r_state;
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hi     <= '0;
         r_lo     <= '0;
         r_b      <= '0;
         r_cnt    <= '0;
         r_op     <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_rd     <= '0;
         r_result <= '0;
         r_rd_out <= '0;
      end else if (w_accept) begin
         r_op    <= funct3;
         r_rd    <= rd_in;
         r_cnt   <= CW'(N);
         r_hi    <= '0;
         r_lo    <= w_is_div ? w_mag1 : w_mag2;
         r_b     <= w_is_div ? w_mag2 : w_mag1;
         r_neg_q <= w_neg1 ^ w_neg2;
         r_neg_r <= w_neg1;
         if (w_fast) begin
            r_result <= w_fast_res;
            r_rd_out <= rd_in;
         end
      end else if (r_state == S_CALC && !flush) begin
         r_hi  <= w_hi_step;
         r_lo  <= w_lo_step;
         r_cnt <= r_cnt - CW'(1);
      end else if (r_state == S_FIX && !flush) begin
         r_result <= w_fix_res;
         r_rd_out <= r_rd;
      end
   end

   assign result = r_result;
   assign rd_out = r_rd_out;

endmodule
